// File: rtl/mac_accumulator.sv
// Signed multiply-accumulate stage: sums a programmed number of products from the multiplier.
// Optional macro MAC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module mac_accumulator #(
    parameter int N  = 4,
    parameter int G  = 4,
    parameter int LW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LW-1:0]      len,
    input  logic               result_ready,
    input  logic [2*N-1:0]     result,
    output logic [2*N+G-1:0]   acc,
    output logic [LW-1:0]      count,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    localparam int AW = 2*N + G;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_acc;
    logic [LW-1:0]   r_count;
    logic [LW-1:0]   r_len;
    logic            r_ovf;
    logic            r_rdy_q;

    logic            w_rise;
    logic [AW-1:0]   w_ext;
    logic [AW-1:0]   w_sum;
    logic            w_add_ovf;
    logic [AW-1:0]   w_acc_nxt;
    logic [LW-1:0]   w_count_nxt;

    assign w_rise      = result_ready & ~r_rdy_q;
    assign w_ext       = {{G{result[2*N-1]}}, result};
    assign w_sum       = r_acc + w_ext;
    assign w_count_nxt = r_count + LW'(1);

    // Signed overflow: addends agree in sign but the sum does not.
    assign w_add_ovf = (r_acc[AW-1] == w_ext[AW-1]) && (w_sum[AW-1] != r_acc[AW-1]);

    always_comb begin
        w_acc_nxt = w_sum;
`ifdef MAC_SATURATE_EN
        if (w_add_ovf) begin
            if (r_acc[AW-1])
                w_acc_nxt = {1'b1, {(AW-1){1'b0}}};
            else
                w_acc_nxt = {1'b0, {(AW-1){1'b1}}};
        end
`else
        w_acc_nxt = w_sum;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
            r_rdy_q <= 1'b0;
        end else begin
            r_rdy_q <= result_ready;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len   <= len;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_rise) begin
                        r_acc   <= w_acc_nxt;
                        r_count <= w_count_nxt;
                        if (w_add_ovf)
                            r_ovf <= 1'b1;
                        if (w_count_nxt == r_len)
                            r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign acc      = r_acc;
    assign count    = r_count;
    assign overflow = r_ovf;
    assign busy     = (r_state == ACCUM);
    assign done     = (r_state == DONE);

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed and randomized bench for mac_accumulator against an integer-arithmetic reference model.
module tb_mac_accumulator;

    localparam int N    = 4;
    localparam int G    = 4;
    localparam int LW   = 8;
    localparam int AW   = 2*N + G;
    localparam int MAXV = (1 << (AW-1)) - 1;
    localparam int MINV = -(1 << (AW-1));

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [LW-1:0]   len;
    logic            result_ready;
    logic [2*N-1:0]  result;
    logic [AW-1:0]   acc;
    logic [LW-1:0]   count;
    logic            busy;
    logic            done;
    logic            overflow;

    int checks   = 0;
    int failures = 0;

    int m_acc, m_count, m_len;
    bit m_ovf, m_busy;

    mac_accumulator #(.N(N), .G(G), .LW(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .result_ready(result_ready), .result(result),
        .acc(acc), .count(count), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum, then wrap or clamp into the AW-bit signed range.
    task automatic model_add(input int p);
        int s;
        s = m_acc + p;
        if (s > MAXV || s < MINV) begin
            m_ovf = 1'b1;
`ifdef MAC_SATURATE_EN
            s = (s > MAXV) ? MAXV : MINV;
`else
            s = (s > MAXV) ? s - (1 << AW) : s + (1 << AW);
`endif
        end
        m_acc = s;
        m_count++;
        if (m_count == m_len) m_busy = 1'b0;
    endtask

    task automatic do_start(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = LW'(l);
        @(negedge clk);
        start  = 1'b0;
        m_acc  = 0; m_count = 0; m_ovf = 1'b0; m_len = l;
        m_busy = (l != 0);
        check("start_busy", int'(busy), int'(l != 0));
        check("start_done", int'(done), int'(l == 0));
        check("start_acc", $signed(acc), 0);
        check("start_count", int'(count), 0);
    endtask

    task automatic pulse(input int p, input int hold);
        bit was_busy;
        was_busy = m_busy;
        @(negedge clk);
        result_ready = 1'b1;
        result       = (2*N)'(p);
        @(negedge clk);
        if (was_busy) model_add(p);
        check("pulse_acc", $signed(acc), m_acc);
        check("pulse_count", int'(count), m_count);
        check("pulse_done", int'(done), int'(was_busy && !m_busy));
        check("pulse_busy", int'(busy), int'(m_busy));
        repeat (hold - 1) @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic end_check();
        @(negedge clk);
        check("end_done", int'(done), 0);
        check("end_busy", int'(busy), 0);
        check("end_acc", $signed(acc), m_acc);
        check("end_count", int'(count), m_count);
        check("end_ovf", int'(overflow), int'(m_ovf));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; result_ready = 1'b0; result = '0;
        m_acc = 0; m_count = 0; m_len = 0; m_ovf = 1'b0; m_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_acc", $signed(acc), 0);
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ovf", int'(overflow), 0);
        reset = 1'b0;

        // Basic run
        do_start(3);
        pulse(6, 1);
        repeat (2) @(negedge clk);
        pulse(-15, 1);
        pulse(64, 1);
        end_check();
        check("basic_acc55", $signed(acc), 55);

        // Level-held ready counts once
        do_start(2);
        pulse(10, 5);
        check("level_count1", int'(count), 1);
        check("level_acc10", $signed(acc), 10);
        pulse(-3, 1);
        end_check();
        check("level_acc7", $signed(acc), 7);

        // Zero length
        do_start(0);
        end_check();
        check("zero_acc", $signed(acc), 0);

        // Positive overflow
        do_start(40);
        for (int i = 0; i < 40; i++) pulse(64, 1);
        end_check();
`ifdef MAC_SATURATE_EN
        check("ovf_pos_const", $signed(acc), 2047);
`else
        check("ovf_pos_const", $signed(acc), -1536);
`endif
        check("ovf_pos_flag", int'(overflow), 1);

        // Negative overflow
        do_start(40);
        for (int i = 0; i < 40; i++) pulse(-56, 1);
        end_check();
`ifdef MAC_SATURATE_EN
        check("ovf_neg_const", $signed(acc), -2048);
`else
        check("ovf_neg_const", $signed(acc), 1856);
`endif
        check("ovf_neg_flag", int'(overflow), 1);

        // Start ignored during ACCUM, then asynchronous reset mid-run
        do_start(4);
        pulse(20, 1);
        pulse(-7, 1);
        @(negedge clk);
        start = 1'b1; len = LW'(1);
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", int'(busy), 1);
        check("ign_acc", $signed(acc), 13);
        check("ign_count", int'(count), 2);
        pulse(1, 1);
        check("ign_len_kept", int'(done), 0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_acc", $signed(acc), 0);
        check("arst_count", int'(count), 0);
        check("arst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        m_acc = 0; m_count = 0; m_ovf = 1'b0; m_busy = 1'b0;
        do_start(1);
        pulse(-8, 1);
        end_check();
        check("fresh_acc", $signed(acc), -8);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            int l;
            l = int'($urandom_range(1, 6));
            do_start(l);
            for (int k = 0; k < l; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (k > 0 && $urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    start = 1'b1; len = LW'($urandom_range(0, 255));
                    @(negedge clk);
                    start = 1'b0;
                end
                pulse(int'($urandom_range(0, 255)) - 128, int'($urandom_range(1, 3)));
            end
            end_check();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream consumer of the Booth multiplier's `result` / `result_ready` outputs.
- Sums a programmed number of signed products into a guarded accumulator (dot-product / MAC stage).
- Reports completion and overflow to the controlling logic.
- Pure sequential stage: edge-detects `result_ready`, counts products, and runs a 3-state FSM.

Parameters:
- N, 4: multiplier operand width; product width is 2N.
- G, 4: accumulator guard bits; accumulator width AW = 2N+G.
- LW, 8: width of the product-count / length fields.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a new accumulation run; sampled only in IDLE.
- len  in  LW  number of products in the run; captured when start is accepted.
- result_ready  in  1  multiplier product-valid level.
- result  in  2N  signed two's-complement product from the multiplier.
- acc  out  AW  signed running / final sum.
- count  out  LW  products accumulated so far in the current run.
- busy  out  1  high while in ACCUM.
- done  out  1  one-cycle pulse, high while in DONE.
- overflow  out  1  sticky: high if any addition in the run overflowed AW signed range.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; acc=0, count=0, overflow=0, len_q=0, rdy_q=0.
  - busy=0, done=0.
- Edge detect:
  - rdy_q <= result_ready every cycle, in every state.
  - rise = result_ready & ~rdy_q.
  - A level held high for many cycles yields exactly one rise.
- IDLE, with start=1:
  - len_q <= len; acc <= 0; count <= 0; overflow <= 0.
  - Next state is DONE if len==0, else ACCUM.
  - A rise in the same cycle as start is not captured.
- IDLE, with start=0: hold all registers. acc retains the last run's sum.
- ACCUM, on rise:
  - acc <= acc + sign_extend(result, AW); count <= count+1.
  - Overflow on this add: both addends have the same sign and the sum's sign differs. Set overflow=1 (sticky for the run).
  - If count+1 == len_q, next state is DONE at the same edge.
- ACCUM, no rise: hold all registers.
- ACCUM, start asserted: ignored.
- DONE:
  - done=1 for exactly one cycle, then unconditionally go to IDLE.
  - start is ignored in DONE.
  - acc, count and overflow are held and remain valid into IDLE until the next accepted start.
- Latency:
  - acc and count reflect a product one cycle after the clk edge on which rise is sampled high.
  - done is high in the cycle immediately after the final accumulating edge.
- Outputs: busy = (state==ACCUM); done = (state==DONE). Both decoded from registered state, glitch-free.
- Arithmetic and width rules:
  - result is always interpreted as signed.
  - Wrap-around is modulo 2^AW unless the optional feature is enabled.
- Reset mid-run: immediate return to IDLE with all registers cleared. A result_ready held high across reset deassertion registers as a rise only if in ACCUM.
- State encoding: 2 bits; IDLE=0, ACCUM=1, DONE=2. The unused code 3 returns to IDLE.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined: on an overflowing add, clamp acc to the sign-appropriate limit and keep accumulating from the clamped value.
  - Positive overflow gives +(2^(AW-1)-1).
  - Negative overflow gives -(2^(AW-1)).
  - overflow is still set.
- Not defined: acc wraps modulo 2^AW; overflow is still set.

Test Plan:
- Basic run: len=3, then products 6, -15, 64, each a single-cycle result_ready pulse with idle gaps.
  - Expected: acc=55, count=3, one done pulse, overflow=0, busy low after done.
- Level-held ready: result_ready held high 5 cycles with result=10 during a len=2 run.
  - Expected: count=1, acc=10 after the level.
  - A second pulse of -3 then gives acc=7 and done.
- Zero length: start with len=0.
  - Expected: done pulses the next cycle, acc=0, count=0, busy never asserted.
- Overflow (AW=12): len=40, 40 products of 64.
  - Without MAC_SATURATE_EN: overflow=1, final acc=-1536.
  - With MAC_SATURATE_EN: final acc=2047.
  - Negative case: 40 products of -56 gives -2048 saturated, or 1856 wrapped.
- Start ignored and reset mid-run:
  - start asserted during ACCUM: len_q and acc unchanged.
  - reset asserted after 2 of 4 products: acc=0, count=0, state IDLE immediately (asynchronous).
  - A fresh start with len=1 and product -8 gives acc=-8 and done.
